// File: rtl/byte_link.sv
// byte_link: deframes 5-byte RX command frames into 32-bit words for the
// command FIFO, and serialises 32-bit responses into 5-byte TX frames.
module byte_link #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] cmd_wrdata,
  output logic        cmd_wrreq,
  input  logic        cmd_full,
  input  logic [31:0] rsp_rddata,
  output logic        rsp_rdreq,
  input  logic        rsp_empty,
  output logic [7:0]  err_cnt
);

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned TIMER_W = 16;
  localparam int unsigned ERR_W   = 8;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    R_SYNC, R_D3, R_D2, R_D1, R_D0, R_PUSH
  } rx_state_e;

  typedef enum logic [2:0] {
    T_IDLE, T_LOAD, T_SYNC, T_D3, T_D2, T_D1, T_D0
  } tx_state_e;

  rx_state_e            rx_state_q, rx_state_d;
  logic [WORD_W-1:0]    word_q, word_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic                 rx_err;
  logic                 rx_ready_c;
  logic                 rx_acc;
  logic                 cmd_wrreq_c;

  tx_state_e            tx_state_q, tx_state_d;
  logic [WORD_W-1:0]    hold_q, hold_d;
  logic                 rsp_rdreq_c;
  logic                 tx_valid_c;
  logic [BYTE_W-1:0]    tx_data_c;

  // RX deframer: next state, shift register, inter-byte timer, error event
  always_comb begin
    rx_state_d  = rx_state_q;
    word_d      = word_q;
    timer_d     = '0;
    rx_err      = 1'b0;
    cmd_wrreq_c = 1'b0;
    rx_ready_c  = (rx_state_q != R_PUSH);
    rx_acc      = rx_valid && rx_ready_c;
    case (rx_state_q)
      R_SYNC: begin
        if (rx_acc) begin
          if (rx_data == SYNC_BYTE) rx_state_d = R_D3;
          else                      rx_err     = 1'b1;
        end
      end
      R_D3, R_D2, R_D1, R_D0: begin
        if (rx_acc) begin
          // A byte on the expiry cycle still counts, so it is checked first
          word_d = {word_q[WORD_W-BYTE_W-1:0], rx_data};
          case (rx_state_q)
            R_D3:    rx_state_d = R_D2;
            R_D2:    rx_state_d = R_D1;
            R_D1:    rx_state_d = R_D0;
            default: rx_state_d = R_PUSH;
          endcase
        end else if (timer_q == TIMER_LAST) begin
          rx_state_d = R_SYNC;
          rx_err     = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      R_PUSH: begin
        cmd_wrreq_c = !cmd_full;
        if (cmd_wrreq_c) rx_state_d = R_SYNC;
      end
      default: rx_state_d = R_SYNC;
    endcase
  end

  // RX state, assembled word and timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= R_SYNC;
      word_q     <= '0;
      timer_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      word_q     <= word_d;
      timer_q    <= timer_d;
    end
  end

  // Saturating framing-error counter
  always_comb begin
    err_d = err_q;
    if (rx_err && (err_q != '1)) err_d = err_q + 1'b1;
  end

  // Error counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end

  // TX serialiser: FIFO read, holding-register load, byte sequencing
  always_comb begin
    tx_state_d  = tx_state_q;
    hold_d      = hold_q;
    rsp_rdreq_c = 1'b0;
    tx_valid_c  = 1'b0;
    tx_data_c   = '0;
    case (tx_state_q)
      T_IDLE: begin
        rsp_rdreq_c = !rsp_empty;
        if (rsp_rdreq_c) tx_state_d = T_LOAD;
      end
      T_LOAD: begin
        hold_d     = rsp_rddata;
        tx_state_d = T_SYNC;
      end
      T_SYNC: begin
        tx_valid_c = 1'b1;
        tx_data_c  = SYNC_BYTE;
        if (tx_ready) tx_state_d = T_D3;
      end
      T_D3: begin
        tx_valid_c = 1'b1;
        tx_data_c  = hold_q[31:24];
        if (tx_ready) tx_state_d = T_D2;
      end
      T_D2: begin
        tx_valid_c = 1'b1;
        tx_data_c  = hold_q[23:16];
        if (tx_ready) tx_state_d = T_D1;
      end
      T_D1: begin
        tx_valid_c = 1'b1;
        tx_data_c  = hold_q[15:8];
        if (tx_ready) tx_state_d = T_D0;
      end
      T_D0: begin
        tx_valid_c = 1'b1;
        tx_data_c  = hold_q[7:0];
        if (tx_ready) tx_state_d = T_IDLE;
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  // TX state and holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= T_IDLE;
      hold_q     <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      hold_q     <= hold_d;
    end
  end

  // Read strobe is forced low while reset is held, even with a non-empty FIFO
  assign rsp_rdreq  = rsp_rdreq_c & rst_n;
  assign rx_ready   = rx_ready_c;
  assign cmd_wrreq  = cmd_wrreq_c;
  assign cmd_wrdata = word_q;
  assign tx_valid   = tx_valid_c;
  assign tx_data    = tx_data_c;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_byte_link.sv
// Directed testbench for byte_link with TIMEOUT=4.
module tb_byte_link;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] cmd_wrdata;
  logic        cmd_wrreq;
  logic        cmd_full;
  logic [31:0] rsp_rddata;
  logic        rsp_rdreq;
  logic        rsp_empty;
  logic [7:0]  err_cnt;

  int errors = 0;
  int checks = 0;

  // Response FIFO model
  logic [31:0] rsp_mem [8];
  int          rsp_wr = 0;
  int          rsp_rd = 0;

  // Observation logs
  logic [7:0]  tx_log [32];
  int          tx_n = 0;
  int          wr_n = 0;
  int          rd_n = 0;
  int          bad_rd = 0;
  int          stall_err = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  byte_link #(.SYNC_BYTE(8'hA5), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .cmd_wrdata (cmd_wrdata),
    .cmd_wrreq  (cmd_wrreq),
    .cmd_full   (cmd_full),
    .rsp_rddata (rsp_rddata),
    .rsp_rdreq  (rsp_rdreq),
    .rsp_empty  (rsp_empty),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rsp_empty = (rsp_rd == rsp_wr);

  // FIFO read data appears the cycle after the strobe
  always @(posedge clk) begin
    if (rsp_rdreq) begin
      rsp_rddata <= rsp_mem[rsp_rd % 8];
      rsp_rd     <= rsp_rd + 1;
    end
  end

  // Log writes, transmitted bytes, read strobes and TX stall stability
  always @(posedge clk) begin
    if (cmd_wrreq) wr_n = wr_n + 1;
    if (rsp_rdreq) rd_n = rd_n + 1;
    if (rsp_rdreq && rsp_empty) bad_rd = bad_rd + 1;
    if (tx_valid && tx_ready && tx_n < 32) begin
      tx_log[tx_n] = tx_data;
      tx_n = tx_n + 1;
    end
    if (rst_n && prev_stall && (!tx_valid || tx_data != prev_data))
      stall_err = stall_err + 1;
    prev_stall = rst_n && tx_valid && !tx_ready;
    prev_data  = tx_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] w);
    send(8'hA5);
    send(w[31:24]);
    send(w[23:16]);
    send(w[15:8]);
    send(w[7:0]);
  endtask

  // Called in the cycle after the last data byte was accepted
  task automatic check_push(input string tag, input logic [31:0] exp);
    chk({tag, "_wrreq"}, {31'd0, cmd_wrreq}, 32'd1);
    chk({tag, "_data"}, cmd_wrdata, exp);
    chk({tag, "_rdy_push"}, {31'd0, rx_ready}, 32'd0);
    tick();
    chk({tag, "_rdy_after"}, {31'd0, rx_ready}, 32'd1);
    chk({tag, "_wrreq_after"}, {31'd0, cmd_wrreq}, 32'd0);
  endtask

  initial begin
    logic [7:0] tx_exp [10];
    int w0;
    int t0;
    int r0;
    int guard;

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    cmd_full = 1'b0;
    #1;
    tick();
    tick();
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("rst_wrreq", {31'd0, cmd_wrreq}, 32'd0);
    chk("rst_wrdata", cmd_wrdata, 32'd0);
    chk("rst_rdreq", {31'd0, rsp_rdreq}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_err", {24'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    // RX basic
    w0 = wr_n;
    send_frame(32'h12345678);
    check_push("basic", 32'h12345678);
    chk("basic_err", {24'd0, err_cnt}, 32'd0);
    chk("basic_nwr", 32'(wr_n - w0), 32'd1);

    // RX resync after two junk bytes
    send(8'h00);
    send(8'hFF);
    send_frame(32'hDEADBEEF);
    check_push("resync", 32'hDEADBEEF);
    chk("resync_err", {24'd0, err_cnt}, 32'd2);
    // Sync value inside the payload is plain data
    send_frame(32'hA500A501);
    check_push("sync_data", 32'hA500A501);
    chk("sync_data_err", {24'd0, err_cnt}, 32'd2);

    // RX backpressure: full rises with the last byte and stays for 10 cycles
    w0 = wr_n;
    send(8'hA5);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    cmd_full = 1'b1;
    send(8'h04);
    for (int i = 0; i < 10; i++) begin
      chk("bp_rdy", {31'd0, rx_ready}, 32'd0);
      chk("bp_wrreq", {31'd0, cmd_wrreq}, 32'd0);
      tick();
    end
    cmd_full = 1'b0;
    #1;
    chk("bp_nwr_stall", 32'(wr_n - w0), 32'd0);
    check_push("bp", 32'h01020304);
    chk("bp_nwr", 32'(wr_n - w0), 32'd1);

    // RX timeout: four idle cycles after a data byte drop the frame
    w0 = wr_n;
    send(8'hA5);
    send(8'h11);
    tick();
    tick();
    tick();
    chk("to_rdy_expiry", {31'd0, rx_ready}, 32'd1);
    chk("to_err_before", {24'd0, err_cnt}, 32'd2);
    tick();
    chk("to_err", {24'd0, err_cnt}, 32'd3);
    chk("to_nwr", 32'(wr_n - w0), 32'd0);
    // Back in sync hunt: next frame decodes from its own header
    send_frame(32'hAABBCCDD);
    check_push("to_next", 32'hAABBCCDD);
    chk("to_next_err", {24'd0, err_cnt}, 32'd3);

    // Byte on the expiry cycle wins
    send(8'hA5);
    send(8'h11);
    tick();
    tick();
    tick();
    send(8'h22);
    send(8'h33);
    send(8'h44);
    check_push("expiry_byte", 32'h11223344);
    chk("expiry_err", {24'd0, err_cnt}, 32'd3);

    // TX: two responses, tx_ready toggling
    tx_exp = '{8'hA5, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h01};
    t0 = tx_n;
    r0 = rd_n;
    rsp_mem[0] = 32'hCAFEF00D;
    rsp_mem[1] = 32'h00000001;
    tx_ready = 1'b1;
    rsp_wr = 2;
    guard = 0;
    while (tx_n < t0 + 10 && guard < 200) begin
      tick();
      tx_ready = ~tx_ready;
      guard++;
    end
    tx_ready = 1'b1;
    tick();
    tick();
    chk("tx_count", 32'(tx_n - t0), 32'd10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("tx_byte%0d", i), {24'd0, tx_log[(t0 + i) % 32]}, {24'd0, tx_exp[i]});
    chk("tx_rdreq_pulses", 32'(rd_n - r0), 32'd2);
    chk("tx_stable", 32'(stall_err), 32'd0);
    chk("tx_rd_empty", 32'(bad_rd), 32'd0);
    chk("tx_idle_valid", {31'd0, tx_valid}, 32'd0);

    // Reset mid-frame on both paths, with the response FIFO still non-empty
    rsp_mem[2] = 32'h11111111;
    rsp_mem[3] = 32'h98765432;
    tx_ready = 1'b0;
    rsp_wr = 4;
    tick();
    tick();
    send(8'hA5);
    send(8'h12);
    chk("pre_rst_txv", {31'd0, tx_valid}, 32'd1);
    chk("pre_rst_rsp", {31'd0, rsp_empty}, 32'd0);
    w0 = wr_n;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("mid_rst_wrreq", {31'd0, cmd_wrreq}, 32'd0);
    chk("mid_rst_wrdata", cmd_wrdata, 32'd0);
    chk("mid_rst_rdreq", {31'd0, rsp_rdreq}, 32'd0);
    chk("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("mid_rst_err", {24'd0, err_cnt}, 32'd0);
    tick();
    tick();
    chk("rst_nwr", 32'(wr_n - w0), 32'd0);
    t0 = tx_n;
    tx_ready = 1'b1;
    rst_n = 1'b1;
    send_frame(32'hCA11AB77);
    check_push("post_rst", 32'hCA11AB77);
    chk("post_rst_err", {24'd0, err_cnt}, 32'd0);
    guard = 0;
    while (tx_n < t0 + 5 && guard < 50) begin
      tick();
      guard++;
    end
    chk("post_rst_tx_count", 32'(tx_n - t0), 32'd5);
    chk("post_rst_tx0", {24'd0, tx_log[t0 % 32]}, 32'h000000A5);
    chk("post_rst_tx1", {24'd0, tx_log[(t0 + 1) % 32]}, 32'h00000098);
    chk("post_rst_tx2", {24'd0, tx_log[(t0 + 2) % 32]}, 32'h00000076);
    chk("post_rst_tx3", {24'd0, tx_log[(t0 + 3) % 32]}, 32'h00000054);
    chk("post_rst_tx4", {24'd0, tx_log[(t0 + 4) % 32]}, 32'h00000032);

    // Error counter saturates
    for (int i = 0; i < 254; i++) send(8'h00);
    chk("err_254", {24'd0, err_cnt}, 32'd254);
    for (int i = 0; i < 6; i++) send(8'h00);
    chk("err_sat", {24'd0, err_cnt}, 32'h000000FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/byte_link.md
# byte_link

Byte-stream link adapter on the host side of the command FIFO pair. It deframes synchronised 5-byte command frames from a byte receiver into 32-bit words and writes them into the command FIFO. It also reads 32-bit responses from the response FIFO and serialises them into 5-byte frames for a byte transmitter. The RX and TX paths are independent state machines and share only clock, reset and the error counter.

## Interface
- SYNC_BYTE, 8'hA5, frame header byte, both directions
- TIMEOUT, 16'd1000, idle cycles allowed between data bytes of one RX frame (must be >= 2)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid && rx_ready
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter takes byte when tx_valid && tx_ready
- cmd_wrdata  out  32  command word to cmd FIFO
- cmd_wrreq  out  1  cmd FIFO write strobe, one word per cycle asserted
- cmd_full  in  1  cmd FIFO full
- rsp_rddata  in  32  response FIFO read data, valid the cycle after rsp_rdreq
- rsp_rdreq  out  1  response FIFO read strobe
- rsp_empty  in  1  response FIFO empty
- err_cnt  out  8  saturating count of framing errors

## Operation
- RX frame: SYNC_BYTE, then B3, B2, B1, B0. Word = {B3,B2,B1,B0}, MSB first. No escaping: SYNC_BYTE value inside data is plain data.
- RX states: R_SYNC, R_D3, R_D2, R_D1, R_D0, R_PUSH.
  - R_SYNC: byte == SYNC_BYTE -> R_D3. Any other byte is discarded, err_cnt++.
  - R_D3..R_D0: each accepted byte shifts into cmd_wrdata and advances the state. R_D0 goes to R_PUSH.
  - R_PUSH: rx_ready=0. cmd_wrreq = !cmd_full (combinational). When cmd_wrreq=1 -> R_SYNC. Otherwise hold, and cmd_wrdata is held stable.
- rx_ready = 1 in every RX state except R_PUSH.
- Inter-byte timeout applies in R_D3..R_D0 only:
  - The timer clears on state entry and on every accepted byte, and increments on each other cycle.
  - When the timer reaches TIMEOUT-1 and no byte is accepted that cycle: partial word dropped, next state R_SYNC, err_cnt++.
  - A byte accepted on the expiry cycle wins: no timeout, normal advance.
- TX states: T_IDLE, T_LOAD, T_SYNC, T_D3, T_D2, T_D1, T_D0.
  - T_IDLE: rsp_rdreq = !rsp_empty (combinational). If asserted -> T_LOAD.
  - T_LOAD: latch rsp_rddata into the 32-bit TX holding register -> T_SYNC.
  - T_SYNC..T_D0: tx_valid=1. tx_data = SYNC_BYTE, then bits [31:24], [23:16], [15:8], [7:0]. Advance only on tx_ready. T_D0 with tx_ready -> T_IDLE.
- tx_valid=1 with tx_data stable until taken; deasserting tx_valid mid-frame is illegal.
- err_cnt saturates at 8'hFF. If an RX discard and a timeout both qualify in one cycle, that is one increment (they cannot coincide by construction).
- Reset mid-frame: both paths abort. No partial word is written, and the partial TX frame is lost.
- Reset values: rx_ready=1 (R_SYNC), cmd_wrreq=0, cmd_wrdata=0, rsp_rdreq=0 while rst_n low, tx_valid=0, tx_data=0, err_cnt=0, timer=0, both FSMs idle.

## Timing
- RX: last data byte (B0) accepted in cycle N -> R_PUSH in N+1. cmd_wrreq=1 in N+1 if !cmd_full -> rx_ready=1 again in N+2.
- RX frame minimum is 6 cycles at full byte rate (5 bytes plus 1 push cycle).
- TX: rsp_rdreq in cycle M, load in M+1, SYNC byte offered in M+2. With tx_ready held high, last byte taken in M+6 and T_IDLE in M+7. Back-to-back responses take 7 cycles per frame.
- cmd_full rising while in R_PUSH stalls the write. No byte is lost because rx_ready is already 0.
- rsp_rdreq never asserts while rsp_empty=1 or outside T_IDLE.

## Test plan
- RX basic: bytes A5,12,34,56,78 at full rate, cmd_full=0 -> single cmd_wrreq with cmd_wrdata=32'h12345678, one cycle after the 0x78 byte is accepted; err_cnt=0.
- RX resync: bytes 00,FF,A5,DE,AD,BE,EF -> err_cnt=2, one write of 32'hDEADBEEF; a data byte of A5 inside a frame is stored as data.
- RX backpressure: cmd_full=1 for 10 cycles after frame A5,01,02,03,04 -> rx_ready=0 and cmd_wrreq=0 for those cycles. Write of 32'h01020304 occurs in the first cycle cmd_full=0.
- RX timeout (TIMEOUT=4): A5,11 then idle -> after 4 idle cycles state R_SYNC, err_cnt=1, no write. Repeat with the byte arriving on the expiry cycle -> no error, frame completes.
- TX: rsp FIFO holds 32'hCAFEF00D and 32'h00000001, tx_ready toggling 1/0 -> bytes A5,CA,FE,F0,0D,A5,00,00,00,01 in order with stable data during stalls; exactly two rsp_rdreq pulses.
- Reset mid-frame: rst_n low after A5,12 and mid-TX -> all outputs at reset values. A new frame after release is decoded correctly.
